imu_frame_assembler: RTL and testbench
======================================

# imu_frame_assembler

Collects the 16-bit big-endian words from the SPI deserializer into one complete ISM330DHCX sample frame (gyro X/Y/Z, then accel X/Y/Z). It presents the frame to the Kalman filter front end over a valid/ready handshake. It sits directly downstream of the deserializer, in the same SPI clock domain. It also tracks frames the consumer could not accept in time and frames cut short by chip-select.

## Interface
Parameters:
- SEQ_W, 8, width of the frame sequence number.
- CNT_W, 8, width of the saturating error counters.

Ports:
- rp2350_sck  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rp2350_cs  in  1  SPI chip select, active low; high means no transaction.
- word_in  in  16  signed big-endian word from the deserializer.
- word_valid  in  1  one-cycle strobe; word_in is valid in this cycle.
- frame_ready  in  1  consumer can accept the frame this cycle.
- frame_valid  out  1  frame_data holds a complete, unconsumed frame.
- frame_data  out  96  {gx, gy, gz, ax, ay, az}; gx is in bits [95:80].
- frame_seq  out  SEQ_W  sequence number of the frame on frame_data.
- overflow_cnt  out  CNT_W  count of frames dropped because the output was still occupied; saturating.
- short_cnt  out  CNT_W  count of partial frames discarded on a chip-select rise; saturating.

## Operation
- Word index idx runs 0..N-1, with N = 6.
  - Words 0..N-2 are written into a staging register at slot idx.
  - The word at idx = N-1 completes the frame. That edge forms the full frame as {staging, word_in}.
- Two states: COLLECT (idx < N-1) and LAST (idx = N-1). The completing word returns idx to 0.
- On a completing edge, the result depends on the output register:
  - Output empty, or being consumed on that same edge (frame_valid & frame_ready): load frame_data, set frame_valid = 1, increment frame_seq. frame_seq wraps modulo 2^SEQ_W.
  - Output occupied and frame_ready = 0: drop the new frame. frame_data and frame_seq stay unchanged. overflow_cnt increments, saturating at all-ones.
- Consume: frame_valid & frame_ready on an edge with no completing word clears frame_valid. frame_data holds its last value.
- Chip select high on an edge:
  - A word_valid on the same edge is processed first.
  - If idx is then nonzero, the partial frame is discarded: idx goes to 0 and short_cnt increments, saturating.
  - A frame completed on that edge is delivered normally.
- word_valid while rp2350_cs is low and idx = 0 starts a new frame. No alignment beyond chip select is performed.
- The output register is never modified while frame_valid = 1 and frame_ready = 0.

## Timing
- Reset values:
  - frame_valid = 0, frame_data = 0, frame_seq = all-ones, so the first delivered frame carries 0.
  - overflow_cnt = 0, short_cnt = 0, idx = 0, staging = 0.
- Latency: frame_valid is high in the cycle after the edge that samples the 6th word_valid.
- frame_data and frame_seq are stable for as long as frame_valid is high.
- Back-to-back operation: a consume and a completion on the same edge keep frame_valid high. The new frame and frame_seq + 1 appear the next cycle.
- Throughput: one frame per N accepted words; no bubble is required between frames.
- Reset asserted mid-frame: all state clears immediately, independent of the clock. The partial frame is lost and is not counted in short_cnt.

## Configuration
- IMU_FRAME_TEMP_EN defined:
  - N = 7. The first word of each frame is the temperature word (the sensor's OUT_TEMP precedes the gyro registers).
  - An extra output temp_out [15:0] is loaded together with frame_data.
  - frame_data layout is unchanged.
- IMU_FRAME_TEMP_EN undefined: N = 6, and temp_out does not exist.

## Test plan
- Reset, then six words 0x0001..0x0006 on consecutive cycles with frame_ready = 1:
  - frame_valid is high one cycle after the 6th word.
  - frame_data = 0x0001_0002_0003_0004_0005_0006; frame_seq = 0.
  - frame_valid drops on the next edge.
- Frame 1 held with frame_ready = 0 while frame 2 completes: frame_data still equals frame 1, overflow_cnt = 1. Then 300 further dropped frames: overflow_cnt = 255, saturated.
- frame_ready asserted on the same edge that frame 2 completes: frame_valid stays high, frame_data = frame 2, frame_seq increments by exactly 1.
- Three words, then rp2350_cs high for one edge, then six new words: short_cnt = 1, and the delivered frame contains only the six new words.
- rst_n pulsed low asynchronously, between clock edges, after four words: all outputs read reset values before the next edge, and the next six words form frame_seq = 0.
- IMU_FRAME_TEMP_EN defined, words 0x0AAA followed by 0x0001..0x0006: temp_out = 0x0AAA and frame_data matches the first scenario.

Source files
------------

// File: rtl/imu_frame_assembler.sv
// Assembles 16-bit deserializer words into one ISM330DHCX sample frame {gx,gy,gz,ax,ay,az}
// behind a valid/ready output register. Define IMU_FRAME_TEMP_EN to expect a leading OUT_TEMP word.
`timescale 1ns/1ps
module imu_frame_assembler #(
  parameter int unsigned SEQ_W = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic             rp2350_sck,
  input  logic             rst_n,
  input  logic             rp2350_cs,
  input  logic [15:0]      word_in,
  input  logic             word_valid,
  input  logic             frame_ready,
  output logic             frame_valid,
  output logic [95:0]      frame_data,
  output logic [SEQ_W-1:0] frame_seq,
  output logic [CNT_W-1:0] overflow_cnt,
`ifdef IMU_FRAME_TEMP_EN
  output logic [15:0]      temp_out,
`endif
  output logic [CNT_W-1:0] short_cnt
);

  localparam int unsigned W           = 16;
  localparam int unsigned FRAME_WORDS = 6;
`ifdef IMU_FRAME_TEMP_EN
  localparam int unsigned N           = 7;
`else
  localparam int unsigned N           = 6;
`endif
  localparam int unsigned IDX_W       = 3;

  typedef enum logic {COLLECT, LAST} state_t;

  state_t                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [N-2:0][W-1:0]       stg_q, stg_d;
  logic                      valid_q, valid_d;
  logic [95:0]               data_q, data_d;
  logic [SEQ_W-1:0]          seq_q, seq_d;
  logic [CNT_W-1:0]          ovf_q, ovf_d;
  logic [CNT_W-1:0]          short_q, short_d;
  logic [W-1:0]              temp_q, temp_d;
  logic                      complete;

  // State and datapath registers
  always_ff @(posedge rp2350_sck or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      idx_q   <= '0;
      stg_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      seq_q   <= '1;
      ovf_q   <= '0;
      short_q <= '0;
      temp_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stg_q   <= stg_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      seq_q   <= seq_d;
      ovf_q   <= ovf_d;
      short_q <= short_d;
      temp_q  <= temp_d;
    end
  end

  // Next-state: word capture, chip-select abort, then output register update
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    stg_d    = stg_q;
    valid_d  = valid_q;
    data_d   = data_q;
    seq_d    = seq_q;
    ovf_d    = ovf_q;
    short_d  = short_q;
    temp_d   = temp_q;
    complete = 1'b0;

    if (word_valid) begin
      if (state_q == LAST) begin
        complete = 1'b1;
        idx_d    = '0;
        state_d  = COLLECT;
      end else begin
        // Slot 0 lands in the most significant staging word
        stg_d[IDX_W'(N-2) - idx_q] = word_in;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(N-2)) state_d = LAST;
      end
    end

    // Chip-select rise discards whatever partial frame remains after this edge's word
    if (rp2350_cs && (idx_d != '0)) begin
      idx_d   = '0;
      state_d = COLLECT;
      if (short_q != '1) short_d = short_q + 1'b1;
    end

    if (complete) begin
      if (!valid_q || frame_ready) begin
        valid_d = 1'b1;
        data_d  = {stg_q[FRAME_WORDS-2:0], word_in};
        seq_d   = seq_q + 1'b1;
        temp_d  = stg_q[N-2];
      end else if (ovf_q != '1) begin
        ovf_d = ovf_q + 1'b1;
      end
    end else if (valid_q && frame_ready) begin
      valid_d = 1'b0;
    end
  end

  assign frame_valid  = valid_q;
  assign frame_data   = data_q;
  assign frame_seq    = seq_q;
  assign overflow_cnt = ovf_q;
  assign short_cnt    = short_q;
`ifdef IMU_FRAME_TEMP_EN
  assign temp_out     = temp_q;
`else
  logic unused_temp;
  assign unused_temp = ^temp_q;
`endif

endmodule

// File: tb/tb_imu_frame_assembler.sv
// Directed self-checking bench for imu_frame_assembler; inputs driven and outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_imu_frame_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cs;
  logic [15:0] word_in;
  logic        word_valid;
  logic        frame_ready;
  logic        frame_valid;
  logic [95:0] frame_data;
  logic [7:0]  frame_seq;
  logic [7:0]  overflow_cnt;
  logic [7:0]  short_cnt;
`ifdef IMU_FRAME_TEMP_EN
  logic [15:0] temp_out;
`endif

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  imu_frame_assembler #(.SEQ_W(8), .CNT_W(8)) dut (
    .rp2350_sck   (clk),
    .rst_n        (rst_n),
    .rp2350_cs    (cs),
    .word_in      (word_in),
    .word_valid   (word_valid),
    .frame_ready  (frame_ready),
    .frame_valid  (frame_valid),
    .frame_data   (frame_data),
    .frame_seq    (frame_seq),
    .overflow_cnt (overflow_cnt),
`ifdef IMU_FRAME_TEMP_EN
    .temp_out     (temp_out),
`endif
    .short_cnt    (short_cnt)
  );

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Back-to-back words starting at base; caller is at a falling edge
  task automatic send_words(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      word_in    = base + 16'(i);
      word_valid = 1'b1;
      @(negedge clk);
    end
    word_valid = 1'b0;
  endtask

  // One full frame; in temperature builds a 0x0AAA temperature word leads
  task automatic send_frame(input logic [15:0] base);
`ifdef IMU_FRAME_TEMP_EN
    word_in    = 16'h0AAA;
    word_valid = 1'b1;
    @(negedge clk);
`endif
    send_words(base, 6);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; cs = 1'b0; word_in = '0; word_valid = 1'b0; frame_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_valid", 96'(frame_valid), 96'(0));
    chk("rst_data",  frame_data, 96'(0));
    chk("rst_seq",   96'(frame_seq), 96'(8'hFF));
    chk("rst_ovf",   96'(overflow_cnt), 96'(0));
    chk("rst_short", 96'(short_cnt), 96'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame
    send_frame(16'h0001);
    chk("f0_valid", 96'(frame_valid), 96'(1));
    chk("f0_data",  frame_data, 96'h0001_0002_0003_0004_0005_0006);
    chk("f0_seq",   96'(frame_seq), 96'(0));
`ifdef IMU_FRAME_TEMP_EN
    chk("f0_temp",  96'(temp_out), 96'(16'h0AAA));
`endif
    @(negedge clk);
    chk("f0_consumed", 96'(frame_valid), 96'(0));

    // Stall: second frame dropped, then saturate overflow
    frame_ready = 1'b0;
    send_frame(16'h0011);
    chk("f1_seq", 96'(frame_seq), 96'(1));
    send_frame(16'h0021);
    chk("drop_valid", 96'(frame_valid), 96'(1));
    chk("drop_data",  frame_data, 96'h0011_0012_0013_0014_0015_0016);
    chk("drop_seq",   96'(frame_seq), 96'(1));
    chk("drop_ovf",   96'(overflow_cnt), 96'(1));
    for (int k = 0; k < 300; k++) send_frame(16'h0100);
    chk("ovf_sat",   96'(overflow_cnt), 96'(8'hFF));
    chk("ovf_data",  frame_data, 96'h0011_0012_0013_0014_0015_0016);

    // Consume and complete on the same edge
`ifdef IMU_FRAME_TEMP_EN
    send_words(16'h0AAA, 1);
`endif
    send_words(16'h0031, 5);
    frame_ready = 1'b1;
    send_words(16'h0036, 1);
    frame_ready = 1'b0;
    chk("b2b_valid", 96'(frame_valid), 96'(1));
    chk("b2b_data",  frame_data, 96'h0031_0032_0033_0034_0035_0036);
    chk("b2b_seq",   96'(frame_seq), 96'(2));
    chk("b2b_ovf",   96'(overflow_cnt), 96'(8'hFF));
    frame_ready = 1'b1;
    @(negedge clk);
    chk("b2b_consumed", 96'(frame_valid), 96'(0));

    // Chip-select abort after three words; second high edge has idx 0 and must not count
    send_words(16'h0051, 3);
    cs = 1'b1;
    @(negedge clk);
    chk("short_one", 96'(short_cnt), 96'(1));
    @(negedge clk);
    cs = 1'b0;
    chk("short_idle", 96'(short_cnt), 96'(1));
    send_frame(16'h0041);
    chk("short_valid", 96'(frame_valid), 96'(1));
    chk("short_data",  frame_data, 96'h0041_0042_0043_0044_0045_0046);
    chk("short_seq",   96'(frame_seq), 96'(3));
    @(negedge clk);

    // Asynchronous reset with a held frame and a partial one in flight
    frame_ready = 1'b0;
    send_frame(16'h0061);
    chk("pre_rst_seq", 96'(frame_seq), 96'(4));
    send_words(16'h0071, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 96'(frame_valid), 96'(0));
    chk("arst_data",  frame_data, 96'(0));
    chk("arst_seq",   96'(frame_seq), 96'(8'hFF));
    chk("arst_ovf",   96'(overflow_cnt), 96'(0));
    chk("arst_short", 96'(short_cnt), 96'(0));
    #1 rst_n = 1'b1;
    @(negedge clk);
    frame_ready = 1'b1;
    send_frame(16'h0081);
    chk("post_rst_valid", 96'(frame_valid), 96'(1));
    chk("post_rst_data",  frame_data, 96'h0081_0082_0083_0084_0085_0086);
    chk("post_rst_seq",   96'(frame_seq), 96'(0));
    chk("post_rst_short", 96'(short_cnt), 96'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
